// File: rtl/pdm_multi.sv
// Multi-channel first-order PDM modulator with shadow/active double buffering and a global commit.
// Optional LFSR dither on the accumulator carry-in is enabled by defining PDM_MULTI_DITHER_EN.
module pdm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                wr_en,
    input  logic                commit,
    input  logic [CHANNELS-1:0] ch_oe,
    output logic [CHANNELS-1:0] pdm_out,
    output logic [CHANNELS-1:0] pdm_oe,
    output logic                commit_ack
);

    logic                wr_valid;
    logic [CHANNELS-1:0] dith;
    logic [CHANNELS-1:0] bit_d;
    logic [CHANNELS-1:0] pdm_q;
    logic [CHANNELS-1:0] oe_q;
    logic                ack_q;

    // Indices past the last channel are dropped entirely, never aliased onto a real channel.
    assign wr_valid = wr_en && ({{(32-AW){1'b0}}, wr_addr} < 32'(CHANNELS));

`ifdef PDM_MULTI_DITHER_EN
    logic [7:0]          lfsr_q;
    logic [CHANNELS-1:0] dith_q;
    logic [CHANNELS-1:0] dith_d;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_dith
        assign dith_d[gi] = lfsr_q[gi % 8] ^ lfsr_q[(gi + 3) % 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 8'h01;
            dith_q <= '0;
        end else begin
            lfsr_q <= {^(lfsr_q & 8'h71), lfsr_q[7:1]};
            dith_q <= dith_d;
        end
    end

    assign dith = dith_q;
`else
    assign dith = '0;
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic             wr_sel;
        logic [WIDTH-1:0] shadow_q;
        logic [WIDTH-1:0] shadow_d;
        logic [WIDTH-1:0] active_q;
        logic [WIDTH-1:0] active_d;
        logic [WIDTH-1:0] acc_q;
        logic [WIDTH:0]   sum;

        assign wr_sel = wr_valid && (wr_addr == AW'(gi));

        // Commit takes the post-write shadow, so a write in the commit cycle bypasses into active.
        always_comb begin
            shadow_d = shadow_q;
            if (wr_sel) begin
                shadow_d = wr_data;
            end
            active_d = active_q;
            if (commit) begin
                active_d = shadow_d;
            end
        end

        assign sum       = {1'b0, acc_q} + {1'b0, active_q} + (WIDTH+1)'(dith[gi]);
        assign bit_d[gi] = sum[WIDTH];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                shadow_q <= '0;
                active_q <= '0;
                acc_q    <= '0;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
                acc_q    <= sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pdm_q <= '0;
            oe_q  <= '0;
            ack_q <= 1'b0;
        end else begin
            pdm_q <= bit_d;
            oe_q  <= ch_oe;
            ack_q <= commit;
        end
    end

    assign pdm_out    = pdm_q;
    assign pdm_oe     = oe_q;
    assign commit_ack = ack_q;

endmodule

// File: tb/tb_pdm_multi.sv
// Scoreboard bench for pdm_multi: stimulus queues windowed ones-count expectations,
// a negedge monitor accumulates DUT bits over each window and compares.
module tb_pdm_multi;

    // Five channels so an out-of-range index (5, 7) is expressible on the 3-bit address bus.
    localparam int W  = 8;
    localparam int CH = 5;
    localparam int AW = 3;
`ifdef PDM_MULTI_DITHER_EN
    localparam bit DITHER = 1'b1;
`else
    localparam bit DITHER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          wr_en;
    logic          commit;
    logic [CH-1:0] ch_oe;
    logic [CH-1:0] pdm_out;
    logic [CH-1:0] pdm_oe;
    logic          commit_ack;

    always #5 clk = ~clk;

    pdm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .commit     (commit),
        .ch_oe      (ch_oe),
        .pdm_out    (pdm_out),
        .pdm_oe     (pdm_oe),
        .commit_ack (commit_ack)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // kind: 0 = pdm_out[ch], 1 = pdm_oe[ch], 2 = commit_ack
    typedef struct {
        int test;
        int kind;
        int ch;
        int start;
        int len;
        int lo;
        int hi;
        int cnt;
        int seen;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic string kname(int kind);
        case (kind)
            0:       return "pdm_out";
            1:       return "pdm_oe";
            default: return "commit_ack";
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].start <= edge_cnt) begin
                if (exp_q[i].seen == 0 && exp_q[i].start < edge_cnt) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL t%0d %s ch%0d: window start %0d already passed at edge %0d",
                             exp_q[i].test, kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].start, edge_cnt);
                    exp_q.delete(i);
                end else begin
                    logic b;
                    case (exp_q[i].kind)
                        0:       b = pdm_out[exp_q[i].ch];
                        1:       b = pdm_oe[exp_q[i].ch];
                        default: b = commit_ack;
                    endcase
                    exp_q[i].cnt  += int'(b);
                    exp_q[i].seen += 1;
                    if (exp_q[i].seen == exp_q[i].len) begin
                        vectors++;
                        if (exp_q[i].cnt < exp_q[i].lo || exp_q[i].cnt > exp_q[i].hi) begin
                            miscompares++;
                            $display("FAIL t%0d %s ch%0d edges %0d+%0d: got %0d ones, need %0d..%0d",
                                     exp_q[i].test, kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].start,
                                     exp_q[i].len, exp_q[i].cnt, exp_q[i].lo, exp_q[i].hi);
                        end else begin
                            $display("ok   t%0d %s ch%0d edges %0d+%0d: %0d ones",
                                     exp_q[i].test, kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].start,
                                     exp_q[i].len, exp_q[i].cnt);
                        end
                        exp_q.delete(i);
                    end
                end
            end
        end
    end

    task automatic expect_win(input int test, input int kind, input int ch, input int start,
                              input int len, input int lo, input int hi);
        exp_t e;
        e.test  = test;
        e.kind  = kind;
        e.ch    = ch;
        e.start = start;
        e.len   = len;
        e.lo    = lo;
        e.hi    = hi;
        e.cnt   = 0;
        e.seen  = 0;
        exp_q.push_back(e);
    endtask

    // V ones per 256 cycles; dither can add at most one extra overflow per 256.
    task automatic expect_rate(input int test, input int ch, input int start, input int v, input int k);
        expect_win(test, 0, ch, start, 256 * k, v * k, v * k + (DITHER ? k : 0));
    endtask

    task automatic expect_ack(input int test, input int t);
        expect_win(test, 2, 0, t, 1, 1, 1);
        expect_win(test, 2, 0, t + 1, 1, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int a, input int d, input bit c);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = W'(d);
        commit  = c;
        step();
        wr_en   = 1'b0;
        commit  = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    int t;
    logic [CH-1:0] oe_pat [6];

    initial begin
        oe_pat[0] = 5'b10101;
        oe_pat[1] = 5'b01010;
        oe_pat[2] = 5'b11111;
        oe_pat[3] = 5'b00000;
        oe_pat[4] = 5'b00110;
        oe_pat[5] = 5'b11001;

        // Reset while write, commit and ch_oe are all asserted: everything must stay cleared.
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'hFF;
        commit  = 1'b1;
        ch_oe   = '1;
        idle(3);
        for (int c = 0; c < CH; c++) begin
            expect_win(0, 0, c, edge_cnt, 1, 0, 0);
            expect_win(0, 1, c, edge_cnt, 1, 0, 0);
        end
        expect_win(0, 2, 0, edge_cnt, 1, 0, 0);
        rst_n  = 1'b1;
        wr_en  = 1'b0;
        commit = 1'b0;
        ch_oe  = '0;
        idle(2);

        // Commit straight after reset: the write seen during reset must not have landed.
        do_commit();
        t = edge_cnt;
        expect_ack(1, t);
        for (int c = 0; c < CH; c++) expect_rate(1, c, t + 1, 0, 1);
        idle(260);

        // ch0 = 0x40 -> 64 ones per 256, others silent.
        wr(0, 8'h40, 1'b0);
        do_commit();
        t = edge_cnt;
        expect_ack(2, t);
        expect_rate(2, 0, t + 1, 8'h40, 1);
        for (int c = 1; c < CH; c++) expect_rate(2, c, t + 1, 0, 1);
        idle(260);

        // Shadow-only write to ch2 has no effect until commit.
        wr(2, 8'hFF, 1'b0);
        t = edge_cnt;
        expect_rate(3, 2, t + 1, 0, 1);
        idle(260);
        do_commit();
        t = edge_cnt;
        expect_rate(3, 2, t + 1, 8'hFF, 1);
        expect_rate(3, 0, t + 1, 8'h40, 1);
        idle(260);

        // Write to ch1 in the commit cycle bypasses straight into active.
        wr(1, 8'h20, 1'b1);
        t = edge_cnt;
        expect_ack(4, t);
        expect_rate(4, 1, t + 1, 8'h20, 1);
        expect_rate(4, 2, t + 1, 8'hFF, 1);
        idle(260);

        // Out-of-range writes, one with commit: no channel may change.
        wr(5, 8'hFF, 1'b0);
        wr(7, 8'h10, 1'b1);
        t = edge_cnt;
        expect_rate(5, 0, t + 1, 8'h40, 1);
        expect_rate(5, 1, t + 1, 8'h20, 1);
        expect_rate(5, 2, t + 1, 8'hFF, 1);
        expect_rate(5, 3, t + 1, 0, 1);
        expect_rate(5, 4, t + 1, 0, 1);
        idle(260);

        // One-cycle reset mid-pattern, with write/commit/ch_oe asserted on the same edge.
        ch_oe = '1;
        idle(3);
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'h80;
        commit  = 1'b1;
        step();
        rst_n  = 1'b1;
        wr_en  = 1'b0;
        commit = 1'b0;
        t = edge_cnt;
        for (int c = 0; c < CH; c++) begin
            expect_win(6, 0, c, t, 1, 0, 0);
            expect_win(6, 1, c, t, 1, 0, 0);
            expect_win(6, 1, c, t + 1, 1, 1, 1);
            expect_rate(6, c, t + 1, 0, 1);
        end
        expect_win(6, 2, 0, t, 1, 0, 0);
        idle(260);
        ch_oe = '0;
        do_commit();
        t = edge_cnt;
        for (int c = 0; c < CH; c++) expect_rate(6, c, t + 1, 0, 1);
        idle(260);

        // 0x80 from acc=0 -> 0,1,0,1 beginning one cycle after the commit edge.
        wr(0, 8'h80, 1'b0);
        do_commit();
        t = edge_cnt;
        expect_ack(7, t);
        expect_win(7, 2, 0, t + 2, 1, 0, 0);
`ifndef PDM_MULTI_DITHER_EN
        for (int j = 0; j < 16; j++) expect_win(7, 0, 0, t + 1 + j, 1, j % 2, j % 2);
`endif
        idle(20);

        // 0x40 over 4096 cycles, while ch_oe toggles with one-cycle-latency checks.
        wr(0, 8'h40, 1'b1);
        t = edge_cnt;
        if (DITHER) expect_win(8, 0, 0, t + 1, 4096, 1024 - 40, 1024 + 40);
        else        expect_win(8, 0, 0, t + 1, 4096, 1024, 1024);
        for (int k = 0; k < 6; k++) begin
            ch_oe = oe_pat[k];
            step();
            for (int c = 0; c < CH; c++)
                expect_win(9, 1, c, edge_cnt, 1, int'(oe_pat[k][c]), int'(oe_pat[k][c]));
        end
        ch_oe = '0;
        idle(4100);

        for (int n = 0; n < 50 && exp_q.size() > 0; n++) step();
        if (exp_q.size() > 0) begin
            $display("FAIL scoreboard: %0d expectations never completed, need 0", exp_q.size());
            vectors     += exp_q.size();
            miscompares += exp_q.size();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
